// File: rtl/fazyrv_rf_xfer.sv
// Word-wide access port for the chunk-serial register file.
// Turns one 32-bit read/write into a full N-cycle rotation of CHUNKSIZE-wide shifts.
//
// state | meaning
// IDLE  | ready for a request; accepts on req_i & en_i
// XFER  | shifting: one chunk out of wdat_sr and one chunk into rdat_sr per cycle
// DONE  | one-cycle ack; rdat_o shows the assembled word
module fazyrv_rf_xfer #(
  parameter int CHUNKSIZE = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 req_i,
  input  logic                 we_req_i,
  input  logic [4:0]           addr_i,
  input  logic [31:0]          wdat_i,
  output logic                 ready_o,
  output logic                 ack_o,
  output logic [31:0]          rdat_o,
  output logic                 rf_shft_o,
  output logic [4:0]           rf_rs1_o,
  output logic [4:0]           rf_rd_o,
  output logic [CHUNKSIZE-1:0] rf_res_o,
  output logic                 rf_we_o,
  input  logic [CHUNKSIZE-1:0] rf_ra_i
);

  localparam int N  = 32 / CHUNKSIZE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0]    addr_lat;
  logic          we_lat;
  logic [31:0]   wdat_sr;
  logic [31:0]   rdat_sr;
  logic [31:0]   rdat_q;
  logic [31:0]   wdat_nxt;
  logic [31:0]   rdat_nxt;
  logic          accept;
  logic          last;

  assign accept = (state == IDLE) & req_i & en_i;
  assign last   = (cnt == CW'(N - 1));

  // With a single 32-bit chunk there is nothing left to shift through.
  generate
    if (CHUNKSIZE == 32) begin : g_full
      assign rdat_nxt = rf_ra_i;
      assign wdat_nxt = '0;
    end else begin : g_part
      assign rdat_nxt = {rf_ra_i, rdat_sr[31:CHUNKSIZE]};
      assign wdat_nxt = {{CHUNKSIZE{1'b0}}, wdat_sr[31:CHUNKSIZE]};
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = XFER;
      XFER:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      addr_lat <= '0;
      we_lat   <= 1'b0;
      wdat_sr  <= '0;
      rdat_sr  <= '0;
      rdat_q   <= '0;
    end else begin
      if (accept) begin
        addr_lat <= addr_i;
        we_lat   <= we_req_i;
        wdat_sr  <= wdat_i;
        cnt      <= '0;
      end
      if (state == XFER) begin
        wdat_sr <= wdat_nxt;
        rdat_sr <= rdat_nxt;
        cnt     <= last ? '0 : cnt + CW'(1);
      end
      if (state == DONE) begin
        rdat_q <= rdat_sr;
      end
    end
  end

  // The read chunk is captured in the same cycle the write chunk lands,
  // so a write returns the register's previous contents.
  always_comb begin
    ready_o   = 1'b0;
    ack_o     = 1'b0;
    rdat_o    = rdat_q;
    rf_shft_o = 1'b0;
    rf_we_o   = 1'b0;
    rf_res_o  = '0;
    case (state)
      IDLE: ready_o = 1'b1;
      XFER: begin
        rf_shft_o = 1'b1;
        rf_we_o   = we_lat & (addr_lat != 5'd0);
        rf_res_o  = wdat_sr[CHUNKSIZE-1:0];
      end
      DONE: begin
        ack_o  = 1'b1;
        rdat_o = rdat_sr;
      end
      default: ;
    endcase
  end

  assign rf_rs1_o = addr_lat;
  assign rf_rd_o  = addr_lat;

endmodule

// File: tb/tb_fazyrv_rf_xfer.sv
// Bench for fazyrv_rf_xfer: four instances (CHUNKSIZE 2, 1, 8, 32), each
// attached to a rotating register-file model, checked against a word-level model.
module tb_fazyrv_rf_xfer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        rf_init;
  logic [3:0]  req_v;
  logic [3:0]  we_v;
  logic [4:0]  addr_v [4];
  logic [31:0] wdat_v [4];
  logic [3:0]  ready_v, ack_v, shft_v, rfwe_v;
  logic [31:0] rdat_v [4];
  logic [31:0] res_v  [4];
  logic [4:0]  rs1_v  [4];
  logic [4:0]  rd_v   [4];
  int          shft_cnt [4];
  int          we_cnt   [4];
  int          ack_cnt  [4];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_rf [4][32];

  always #5 clk = ~clk;

  function automatic int cs_of(int i);
    case (i)
      0:       return 2;
      1:       return 1;
      2:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic logic [31:0] init_val(int k);
    return (k == 0) ? 32'd0 : 32'h0101_0101 * 32'(k);
  endfunction

  // Shift a register right by c bits, filling the top with the low c bits of d.
  function automatic logic [31:0] shin(logic [31:0] r, logic [31:0] d, int c);
    logic [63:0] t;
    t = {d, r} >> c;
    return t[31:0];
  endfunction

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_inst
      localparam int C = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 8 : 32;
      logic [C-1:0] ra, res;
      logic [4:0]   rs1, rd;
      logic         shft, rfwe, ack, rdy;
      logic [31:0]  rdat;
      logic [31:0]  regs [32];
      int           n_shft = 0, n_we = 0, n_ack = 0;

      fazyrv_rf_xfer #(.CHUNKSIZE(C)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .req_i     (req_v[g]),
        .we_req_i  (we_v[g]),
        .addr_i    (addr_v[g]),
        .wdat_i    (wdat_v[g]),
        .ready_o   (rdy),
        .ack_o     (ack),
        .rdat_o    (rdat),
        .rf_shft_o (shft),
        .rf_rs1_o  (rs1),
        .rf_rd_o   (rd),
        .rf_res_o  (res),
        .rf_we_o   (rfwe),
        .rf_ra_i   (ra)
      );

      assign ra = (rs1 == 5'd0) ? '0 : regs[rs1][C-1:0];

      // Every register rotates by one chunk per shift; rd takes the write chunk.
      always @(posedge clk) begin
        for (int k = 0; k < 32; k++) begin
          if (rf_init)
            regs[k] <= init_val(k);
          else if (shft) begin
            if (k == 0)
              regs[k] <= 32'd0;
            else if (rfwe && (k == int'(rd)))
              regs[k] <= shin(regs[k], 32'(res), C);
            else
              regs[k] <= shin(regs[k], regs[k], C);
          end
        end
      end

      always @(posedge clk) begin
        if (shft) n_shft <= n_shft + 1;
        if (rfwe) n_we <= n_we + 1;
        if (ack)  n_ack <= n_ack + 1;
      end

      assign ready_v[g]  = rdy;
      assign ack_v[g]    = ack;
      assign shft_v[g]   = shft;
      assign rfwe_v[g]   = rfwe;
      assign rdat_v[g]   = rdat;
      assign res_v[g]    = 32'(res);
      assign rs1_v[g]    = rs1;
      assign rd_v[g]     = rd;
      assign shft_cnt[g] = n_shft;
      assign we_cnt[g]   = n_we;
      assign ack_cnt[g]  = n_ack;
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the ack cycle (or timeout).
  task automatic do_xfer(input int i, input logic we, input logic [4:0] a,
                         input logic [31:0] d, output logic [31:0] rdat,
                         output int lat, output int ns, output int nw);
    int s0, w0, k;
    k = 0;
    while (!ready_v[i] && k < 200) begin
      @(negedge clk);
      k++;
    end
    we_v[i] = we; addr_v[i] = a; wdat_v[i] = d; req_v[i] = 1'b1; en = 1'b1;
    s0 = shft_cnt[i]; w0 = we_cnt[i];
    @(posedge clk);
    #1 req_v[i] = 1'b0;
    k = 1;
    @(negedge clk);
    while (!ack_v[i] && k < 200) begin
      @(negedge clk);
      k++;
    end
    rdat = rdat_v[i];
    lat  = k;
    ns   = shft_cnt[i] - s0;
    nw   = we_cnt[i] - w0;
  endtask

  task automatic run_op(input int i, input logic we, input logic [4:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    int lat, ns, nw, n;
    n = 32 / cs_of(i);
    do_xfer(i, we, a, d, rd, lat, ns, nw);
    chk({tag, " rdat"}, rd, exp);
    chk({tag, " latency"}, 32'(lat), 32'(n + 1));
    chk({tag, " shifts"}, 32'(ns), 32'(n));
    chk({tag, " we_cycles"}, 32'(nw), (we && a != 5'd0) ? 32'(n) : 32'd0);
    if (we && a != 5'd0) exp_rf[i][a] = d;
    @(negedge clk);
    chk({tag, " ready_after"}, 32'(ready_v[i]), 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tab [9];

  initial begin
    logic [31:0] rd, exp;
    logic        we;
    logic [4:0]  a;
    int          i, k, bad, acks0;

    tab[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 32'h05050505};
    tab[1] = '{1'b0, 5'd5, 32'h0,        32'hDEADBEEF};
    tab[2] = '{1'b0, 5'd4, 32'h0,        32'h04040404};
    tab[3] = '{1'b0, 5'd6, 32'h0,        32'h06060606};
    tab[4] = '{1'b1, 5'd7, 32'h12345678, 32'h07070707};
    tab[5] = '{1'b1, 5'd7, 32'hCAFEF00D, 32'h12345678};
    tab[6] = '{1'b0, 5'd7, 32'h0,        32'hCAFEF00D};
    tab[7] = '{1'b1, 5'd0, 32'hFFFFFFFF, 32'h0};
    tab[8] = '{1'b0, 5'd0, 32'h0,        32'h0};

    rst = 1'b1; rf_init = 1'b1; en = 1'b0; req_v = '0; we_v = '0;
    for (int j = 0; j < 4; j++) begin
      addr_v[j] = '0; wdat_v[j] = '0;
      for (int r = 0; r < 32; r++) exp_rf[j][r] = init_val(r);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("reset%0d ready", j), 32'(ready_v[j]), 32'd1);
      chk($sformatf("reset%0d ack", j),   32'(ack_v[j]),   32'd0);
      chk($sformatf("reset%0d rdat", j),  rdat_v[j],       32'd0);
      chk($sformatf("reset%0d shft", j),  32'(shft_v[j]),  32'd0);
      chk($sformatf("reset%0d we", j),    32'(rfwe_v[j]),  32'd0);
      chk($sformatf("reset%0d res", j),   res_v[j],        32'd0);
      chk($sformatf("reset%0d rs1_rd", j), {rs1_v[j], rd_v[j]}, 32'd0);
    end
    rf_init = 1'b0; rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 9; v++)
      run_op(0, tab[v].we, tab[v].a, tab[v].d, tab[v].exp, $sformatf("vec%0d", v));

    for (int j = 1; j < 4; j++) begin
      run_op(j, 1'b1, 5'd31, 32'hA5A55A5A, 32'h1F1F1F1F, $sformatf("sweep%0d_wr", cs_of(j)));
      run_op(j, 1'b0, 5'd31, 32'h0,        32'hA5A55A5A, $sformatf("sweep%0d_rd", cs_of(j)));
    end

    for (int r = 0; r < 60; r++) begin
      i  = int'($urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      a  = 5'($urandom_range(0, 31));
      exp = (a == 5'd0) ? 32'd0 : exp_rf[i][a];
      run_op(i, we, a, $urandom, exp, $sformatf("rand%0d", r));
    end

    // Held-off request: en_i low keeps the request pending without shifting.
    en = 1'b0; we_v[0] = 1'b0; addr_v[0] = 5'd5; req_v[0] = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (shft_v[0] || !ready_v[0]) bad++;
    end
    chk("gate_hold", 32'(bad), 32'd0);
    en = 1'b1;
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    @(negedge clk);
    chk("gate_start", 32'(shft_v[0]), 32'd1);
    en = 1'b0;
    k = 1;
    while (!ack_v[0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("gate_latency", 32'(k), 32'd17);
    chk("gate_rdat", rdat_v[0], exp_rf[0][5]);
    @(negedge clk);

    // Reset abort on XFER cycle 5 of a write.
    we_v[0] = 1'b1; addr_v[0] = 5'd9; wdat_v[0] = 32'h0BADF00D; req_v[0] = 1'b1; en = 1'b1;
    @(posedge clk);
    #1 req_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_pre_we", 32'(rfwe_v[0]), 32'd1);
    acks0 = ack_cnt[0];
    rst = 1'b1;
    #1;
    chk("abort_shft", 32'(shft_v[0]), 32'd0);
    chk("abort_we",   32'(rfwe_v[0]), 32'd0);
    chk("abort_ack",  32'(ack_v[0]),  32'd0);
    chk("abort_res",  res_v[0],       32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_ready", 32'(ready_v[0]), 32'd1);
    chk("abort_no_ack", 32'(ack_cnt[0] - acks0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end

endmodule
